// File: rtl/div_pkg.sv
// Shared types and constants for the iterative integer divider.
//   div_state_e       : divider control states
//   OP_DIV / OP_MOD   : ALU opcodes served by int_div_unit
//   DIV_WIDTH_DEFAULT : default operand width
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (combinational).
//   rem_i/quo_i : current partial remainder / quotient-dividend shift register
//   dsr_i       : divisor magnitude
//   rem_o/quo_o : values after shifting in one dividend bit and one quotient bit
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Two guard bits so the trial sign is exact even for a full-width divisor.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dsr_i};

    // Both candidates are below the divisor, so the top bits are always zero.
    assign rem_o = trial[WIDTH+1] ? WIDTH'(shifted) : WIDTH'(trial);
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH+1]};

endmodule

// File: rtl/int_div_unit.sv
// Iterative radix-2 restoring divide / modulo unit for the EX stage.
// One quotient bit per cycle; EX stalls on busy and consumes result on done.
// Optional build macro: INT_DIV_EARLY_OUT_EN (skip CALC when |dividend| < |divisor|).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : issue request, accepted only in IDLE
//   op_mod, is_signed : 0=div/1=mod, signed operands
//   dividend, divisor : operands, latched at issue
//   busy              : combinational stall request
//   done              : one-cycle result-valid pulse
//   result            : quotient or remainder selected by latched op_mod
//   quotient, remainder, div_by_zero : raw results and zero-divisor flag
module int_div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH          = DIV_WIDTH_DEFAULT,
    parameter bit          SIGNED_DEFAULT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_mod,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_mod_q, op_mod_d;
    logic             signed_q, signed_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg, dsr_neg;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] fix_quo, fix_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Operand magnitudes; negating MIN wraps back to MIN, read as 2^(WIDTH-1).
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dsr_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dsr_mag = dsr_neg ? -divisor  : divisor;

    // Sign correction, applied only when the operation was issued as signed.
    assign fix_quo = (signed_q & neg_quo_q) ? -quo_q : quo_q;
    assign fix_rem = (signed_q & neg_rem_q) ? -rem_q : rem_q;

    assign busy = ((state_q == IDLE) && start) || (state_q == CALC) || (state_q == FIX);

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_mod_d    = op_mod_q;
        signed_d    = signed_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        result_d    = result_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_mod_d  = op_mod;
                    signed_d  = is_signed;
                    neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d = dividend[WIDTH-1];
                    rem_d     = '0;
                    quo_d     = dvd_mag;
                    dsr_d     = dsr_mag;
                    cnt_d     = CNT_W'(WIDTH);
                    dbz_d     = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor: raw dividend passes through untouched.
                        state_d     = DONE;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        result_d    = op_mod ? dividend : '1;
`ifdef INT_DIV_EARLY_OUT_EN
                    end else if (dvd_mag < dsr_mag) begin
                        state_d = FIX;
                        rem_d   = dvd_mag;
                        quo_d   = '0;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = fix_quo;
                remainder_d = fix_rem;
                result_d    = op_mod_q ? fix_rem : fix_quo;
                done_d      = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_mod_q    <= 1'b0;
            signed_q    <= SIGNED_DEFAULT;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_mod_q    <= op_mod_d;
            signed_q    <= signed_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            result_q    <= result_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign result      = result_q;

endmodule

// File: tb/tb_int_div_unit.sv
// Self-checking bench for int_div_unit: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_int_div_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_mod;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks;
    int n_fails;

    int_div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_mod      (op_mod),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: 64-bit arithmetic (C-style truncating division), latency in
    // negedges after the issue edge at which done is first seen.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz, output int lat);
        longint sa;
        longint sb;
`ifdef INT_DIV_EARLY_OUT_EN
        longint aa;
        longint ab;
`endif
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        if (b == '0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
            lat = 0;
        end else begin
            q   = W'(sa / sb);
            r   = W'(sa % sb);
            dbz = 1'b0;
            lat = W + 1;
`ifdef INT_DIV_EARLY_OUT_EN
            aa = (sa < 0) ? -sa : sa;
            ab = (sb < 0) ? -sb : sb;
            if (aa < ab) lat = 1;
`endif
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sg, input logic om, input bit perturb);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] eres;
        logic         edbz;
        int           elat;
        int           k;
        logic         seen;
        model(a, b, sg, eq, er, edbz, elat);
        eres = om ? er : eq;

        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        op_mod    = om;
        start     = 1'b1;
        #1 chk("busy_issue", W'(busy), W'(1));
        @(negedge clk);
        start = 1'b0;
        chk("dbz_after_issue", W'(div_by_zero), W'(edbz));

        k    = 0;
        seen = 1'b0;
        while (k <= 100) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (perturb) begin
                start     = 1'($urandom_range(0, 1));
                dividend  = $urandom;
                divisor   = $urandom;
                is_signed = 1'($urandom_range(0, 1));
                op_mod    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            k++;
        end
        chk("done_seen", W'(seen), W'(1));
        if (seen) begin
            chk("latency", W'(k), W'(elat));
            chk("quotient", quotient, eq);
            chk("remainder", remainder, er);
            chk("result", result, eres);
            chk("div_by_zero", W'(div_by_zero), W'(edbz));
            chk("busy_at_done", W'(busy), W'(0));
        end
        // A start held through DONE must not launch a new operation.
        start = perturb;
        @(negedge clk);
        start = 1'b0;
        chk("done_single", W'(done), W'(0));
        #1 chk("no_restart", W'(busy), W'(0));
        @(negedge clk);
        chk("still_idle", W'(done), W'(0));
        chk("quotient_hold", quotient, eq);
    endtask

    task automatic rst_mid_op();
        int hits;
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        op_mod    = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        chk("rst_result", result, '0);
        chk("rst_done", W'(done), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_dbz", W'(div_by_zero), W'(0));
        @(negedge clk);
        rst  = 1'b0;
        hits = 0;
        repeat (W + 6) begin
            @(negedge clk);
            if (done) hits++;
        end
        chk("rst_no_done", W'(hits), W'(0));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        op_mod    = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_dbz", W'(div_by_zero), W'(0));
        chk("reset_result", result, '0);
        chk("reset_quotient", quotient, '0);
        chk("reset_remainder", remainder, '0);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 1'b0);
        run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op(32'd123457, 32'd67, 1'b0, 1'b0, 1'b1);
        run_op(32'd3, 32'd10, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFD, 32'd10, 1'b1, 1'b1, 1'b0);
        rst_mid_op();

        for (int i = 0; i < 50; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = b >> $urandom_range(0, 31);
                1: b = '0;
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                4: a = a >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   (b != '0) && ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/int_div_unit.md
Name: int_div_unit

Overview:
- Iterative radix-2 restoring integer divider/modulo unit for the EX stage; implements the div (op 4'b0100) and mod (op 4'b0101) ALU ops.
- Responder side of the EX multi-cycle stall protocol: EX issues `start`; this block drives `busy` so EX can assert BUSY and freeze the pipeline; it pulses `done` when the result is ready.
- One quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SIGNED_DEFAULT, 1, reset value of the internal signed-mode latch (1 = two's-complement operands).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  issue request; sampled only in IDLE.
- op_mod  input  1  0 = div (result = quotient), 1 = mod (result = remainder).
- is_signed  input  1  1 = signed operands, 0 = unsigned.
- dividend  input  WIDTH  A operand (ALU_src1).
- divisor  input  WIDTH  B operand (ALU_src2).
- busy  output  1  stall request to EX.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  quotient or remainder per latched op_mod.
- quotient  output  WIDTH  raw quotient.
- remainder  output  WIDTH  raw remainder.
- div_by_zero  output  1  set with done when divisor was 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, div_by_zero=0.
  - result, quotient and remainder = 0.
  - Iteration counter = 0; signed latch = SIGNED_DEFAULT.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch op_mod and is_signed.
  - Latch the operand magnitudes: for signed mode, absolute value; MIN stays MIN and is treated as unsigned 2^(WIDTH-1).
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear the partial remainder; counter = WIDTH.
  - If divisor == 0, go to DONE; otherwise go to CALC.
- CALC, each cycle:
  - Shift {rem,quo} left by one, bringing in the next dividend bit.
  - trial = rem − divisor_mag. If trial is non-negative, rem = trial and quo LSB = 1; otherwise quo LSB = 0.
  - counter decrements; when it reaches 1, go to FIX.
  - CALC lasts exactly WIDTH cycles.
- FIX, one cycle:
  - Signed mode: negate quotient if sign_q; negate remainder if sign_r.
  - Register quotient, remainder and result; go to DONE.
- DONE, one cycle:
  - done=1, busy=0; go to IDLE.
  - A start in DONE is ignored; it must be re-presented in IDLE.
- Latency: start sampled at edge N → done high in cycle N+WIDTH+2 (34 cycles for WIDTH=32).
- busy is combinational: busy = (state==IDLE && start) || state==CALC || state==FIX. EX therefore stalls in the issue cycle itself.
- start while busy is ignored. Operands are latched, so EX operand changes during CALC have no effect.
- Outputs hold their values until the next FIX or DONE overwrites them.
- Divide by zero:
  - Start → DONE in 1 cycle: done at N+1.
  - quotient = all-ones, remainder = dividend (unmodified), result selected by op_mod, div_by_zero=1.
  - div_by_zero clears on the next accepted start.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/−1 gives quotient = MIN, remainder = 0 (natural wrap, no flag).
- Unsigned mode skips all sign logic.
- rst mid-operation aborts immediately to reset values; no done pulse.

Optional Feature:
- Macro: INT_DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if divisor != 0 and |dividend| < |divisor|, go straight to FIX with quotient magnitude 0 and remainder magnitude |dividend|.
  - done arrives at N+2. busy covers the start cycle and the FIX cycle.
- Undefined: always the full WIDTH-cycle CALC; latency fixed at WIDTH+2.

Decomposition:
- Shared package div_pkg:
  - State enum (IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11).
  - Op constants OP_DIV=4'b0100, OP_MOD=4'b0101.
  - Default WIDTH constant.
- One sub-module div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor_mag. Outputs: next rem, next quo.
  - Instantiated once in CALC.

Test Plan:
- Unsigned 100 / 7, op_mod=0 → busy in the start cycle, done at N+34, result=14, remainder=2, div_by_zero=0.
- Signed −100 / 7, op_mod=1 → quotient=0xFFFFFFF2 (−14), result=remainder=0xFFFFFFFE (−2).
- Divisor=0, dividend=0x1234 → done at N+1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1; next start clears the flag.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, no flag.
- Start pulses during CALC with changed operands, plus start held high in DONE → result unaffected, exactly one done pulse, no new operation begins until IDLE.
- Assert rst at CALC cycle 10 → all outputs 0 immediately, no done.
- With INT_DIV_EARLY_OUT_EN: 3 / 10 → done at N+2, quotient 0, remainder 3.
